// File: rtl/muldiv_sequencer.sv
// Multi-cycle sequencer for integer mult/multu/div/divu.
// Radix-2 shift-add multiply and restoring divide, one iteration per cycle.
// The sign is fixed up at the end; divide-by-zero short-circuits to DONE.
//
// state | meaning
// IDLE  | waiting for start; operands latched on accept
// SETUP | take magnitudes, record signs, detect divide-by-zero
// RUN   | WIDTH iterations of shift-add or restoring subtract
// FIX   | apply sign correction and register result/remainder
// DONE  | one-cycle done pulse; may accept a back-to-back start
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             ready,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] remainder,
  output logic             div0
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_RUN, S_FIX, S_DONE} state_t;

  state_t           state, next_state;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] mcand;      // multiplicand or divisor magnitude
  logic [WIDTH-1:0] acc_hi;     // product high half / partial remainder
  logic [WIDTH-1:0] acc_lo;     // multiplier bits / quotient bits
  logic             sign_q, sign_r;
  logic [CW-1:0]    counter;

  logic             is_div, is_signed, div_zero, accept;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   mult_sum;
  logic [WIDTH:0]   rem_sh;
  logic             rem_ge;
  logic [WIDTH-1:0] rem_sub;
  logic [2*WIDTH-1:0] prod, prod_neg;

  // Operand conditioning and per-iteration arithmetic.
  always_comb begin
    is_div    = op_q[1];
    is_signed = ~op_q[0];
    a_abs     = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
    b_abs     = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;
    div_zero  = is_div && (b_q == '0);
    mult_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
    rem_sh    = {acc_hi, acc_lo[WIDTH-1]};
    rem_ge    = rem_sh >= {1'b0, mcand};
    // Only used when rem_ge, so the difference always fits in WIDTH bits.
    rem_sub   = rem_sh[WIDTH-1:0] - mcand;
    prod      = {acc_hi, acc_lo};
    prod_neg  = -prod;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // Next-state and handshake outputs.
  always_comb begin
    next_state = state;
    ready      = (state == S_IDLE) || (state == S_DONE);
    accept     = ready && start;
    stall      = (state == S_SETUP) || (state == S_RUN) || (state == S_FIX) || accept;
    done       = (state == S_DONE);
    case (state)
      S_IDLE:  if (start) next_state = S_SETUP;
      S_SETUP: next_state = div_zero ? S_DONE : S_RUN;
      S_RUN:   if (counter == '0) next_state = S_FIX;
      S_FIX:   next_state = S_DONE;
      S_DONE:  next_state = start ? S_SETUP : S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, sign fix-up and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      mcand     <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      counter   <= '0;
      result    <= '0;
      remainder <= '0;
      div0      <= 1'b0;
    end else begin
      if (accept) begin
        op_q <= op;
        a_q  <= opa;
        b_q  <= opb;
      end
      case (state)
        S_SETUP: begin
          sign_q <= is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          sign_r <= is_signed & a_q[WIDTH-1];
          if (div_zero) begin
            result    <= '1;
            remainder <= a_q;
            div0      <= 1'b1;
          end else begin
            counter <= CW'(WIDTH - 1);
            mcand   <= is_div ? b_abs : a_abs;
            acc_lo  <= is_div ? a_abs : b_abs;
            acc_hi  <= '0;
          end
        end
        S_RUN: begin
          if (is_div) begin
            acc_hi <= rem_ge ? rem_sub : rem_sh[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], rem_ge};
          end else begin
            acc_hi <= mult_sum[WIDTH:1];
            acc_lo <= {mult_sum[0], acc_lo[WIDTH-1:1]};
          end
          if (counter != '0) counter <= counter - CW'(1);
        end
        S_FIX: begin
          div0 <= 1'b0;
          if (is_div) begin
            result    <= sign_q ? -acc_lo : acc_lo;
            remainder <= sign_r ? -acc_hi : acc_hi;
          end else if (sign_q) begin
            {remainder, result} <= prod_neg;
          end else begin
            {remainder, result} <= prod;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer (WIDTH=32).
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] opa = '0;
  logic [31:0] opb = '0;
  logic        ready, stall, done, div0;
  logic [31:0] result, remainder;

  int n_cmp = 0;
  int n_err = 0;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .opa(opa), .opb(opb),
    .ready(ready), .stall(stall), .done(done), .result(result),
    .remainder(remainder), .div0(div0)
  );

  always #5 clk = ~clk;

  // Present a request at a negedge and let it be accepted on the next posedge.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; opa = a; opb = b;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts negedges after the accept edge until done; 0 means timeout.
  task automatic wait_done(output int lat);
    lat = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    #2;
    n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", ready); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", stall); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (result !== 32'h0 || remainder !== 32'h0 || div0 !== 1'b0) begin
      n_err++; $display("FAIL reset_outputs: got %h/%h/%b want 0/0/0", result, remainder, div0);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mult;
    int lat;
    issue(2'b00, 32'd7, -32'sd3);
    wait_done(lat);
    n_cmp++; if (lat !== 35) begin n_err++; $display("FAIL mult_latency: got %0d want 35", lat); end
    n_cmp++; if (result !== 32'hFFFFFFEB) begin n_err++; $display("FAIL mult_result: got %h want FFFFFFEB", result); end
    n_cmp++; if (remainder !== 32'hFFFFFFFF) begin n_err++; $display("FAIL mult_high: got %h want FFFFFFFF", remainder); end
    n_cmp++; if (div0 !== 1'b0) begin n_err++; $display("FAIL mult_div0: got %b want 0", div0); end
    issue(2'b00, -32'sd5, -32'sd6);
    wait_done(lat);
    n_cmp++; if (result !== 32'd30 || remainder !== 32'd0) begin
      n_err++; $display("FAIL mult_negneg: got %h/%h want 0000001E/00000000", result, remainder);
    end
  endtask

  task automatic test_multu;
    int lat;
    issue(2'b01, 32'hFFFFFFFF, 32'd2);
    wait_done(lat);
    n_cmp++; if (lat !== 35) begin n_err++; $display("FAIL multu_latency: got %0d want 35", lat); end
    n_cmp++; if (result !== 32'hFFFFFFFE) begin n_err++; $display("FAIL multu_result: got %h want FFFFFFFE", result); end
    n_cmp++; if (remainder !== 32'h00000001) begin n_err++; $display("FAIL multu_high: got %h want 00000001", remainder); end
    // Outputs hold after the done pulse.
    repeat (3) @(negedge clk);
    n_cmp++; if (done !== 1'b0 || result !== 32'hFFFFFFFE || remainder !== 32'h1) begin
      n_err++; $display("FAIL multu_hold: got %b %h/%h want 0 FFFFFFFE/00000001", done, result, remainder);
    end
  endtask

  task automatic test_div;
    int lat;
    issue(2'b10, -32'sd17, 32'd5);
    wait_done(lat);
    n_cmp++; if (lat !== 35) begin n_err++; $display("FAIL div_latency: got %0d want 35", lat); end
    n_cmp++; if (result !== 32'hFFFFFFFD) begin n_err++; $display("FAIL div_quot: got %h want FFFFFFFD", result); end
    n_cmp++; if (remainder !== 32'hFFFFFFFE) begin n_err++; $display("FAIL div_rem: got %h want FFFFFFFE", remainder); end
    n_cmp++; if (div0 !== 1'b0) begin n_err++; $display("FAIL div_div0: got %b want 0", div0); end
    issue(2'b10, 32'h80000000, 32'hFFFFFFFF);
    wait_done(lat);
    n_cmp++; if (result !== 32'h80000000 || remainder !== 32'h0) begin
      n_err++; $display("FAIL div_min_neg1: got %h/%h want 80000000/00000000", result, remainder);
    end
    issue(2'b11, 32'd100, 32'd7);
    wait_done(lat);
    n_cmp++; if (result !== 32'd14 || remainder !== 32'd2) begin
      n_err++; $display("FAIL divu_basic: got %h/%h want 0000000E/00000002", result, remainder);
    end
  endtask

  task automatic test_div0;
    int lat;
    issue(2'b11, 32'd9, 32'd0);
    wait_done(lat);
    n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL div0_latency: got %0d want 2", lat); end
    n_cmp++; if (div0 !== 1'b1) begin n_err++; $display("FAIL div0_flag: got %b want 1", div0); end
    n_cmp++; if (result !== 32'hFFFFFFFF) begin n_err++; $display("FAIL div0_result: got %h want FFFFFFFF", result); end
    n_cmp++; if (remainder !== 32'd9) begin n_err++; $display("FAIL div0_rem: got %h want 00000009", remainder); end
  endtask

  task automatic test_back_to_back;
    int lat;
    int extra;
    issue(2'b01, 32'd3, 32'd4);
    wait_done(lat);
    // Now in the DONE cycle: present the next request immediately.
    start = 1'b1; op = 2'b01; opa = 32'd6; opb = 32'd7;
    #1;
    n_cmp++; if (stall !== 1'b1 || ready !== 1'b1) begin
      n_err++; $display("FAIL b2b_stall_ready: got %b/%b want 1/1", stall, ready);
    end
    @(posedge clk);
    #1 start = 1'b0;
    // Pulse start while busy with different operands; must be ignored.
    repeat (3) @(negedge clk);
    start = 1'b1; opa = 32'd100; opb = 32'd100;
    @(negedge clk);
    start = 1'b0;
    extra = 0;
    lat = 0;
    for (int k = 5; k <= 100; k++) begin
      @(negedge clk);
      if (done) begin
        if (lat == 0) lat = k;
        else extra++;
      end
    end
    n_cmp++; if (lat !== 35) begin n_err++; $display("FAIL b2b_latency: got %0d want 35", lat); end
    n_cmp++; if (result !== 32'd42 || remainder !== 32'd0) begin
      n_err++; $display("FAIL b2b_result: got %h/%h want 0000002A/00000000", result, remainder);
    end
    n_cmp++; if (extra !== 0) begin n_err++; $display("FAIL ignore_extra_done: got %0d want 0", extra); end
  endtask

  task automatic test_reset_mid_op;
    int lat;
    int seen;
    issue(2'b01, 32'd5, 32'd5);
    // RUN starts two cycles after accept with counter 31; counter is 10 at negedge 23.
    repeat (23) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (ready !== 1'b1 || stall !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL midrst_ctrl: got r%b s%b d%b want r1 s0 d0", ready, stall, done);
    end
    n_cmp++; if (result !== 32'h0 || remainder !== 32'h0 || div0 !== 1'b0) begin
      n_err++; $display("FAIL midrst_outputs: got %h/%h/%b want 0/0/0", result, remainder, div0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL midrst_no_done: got %0d want 0", seen); end
    issue(2'b00, 32'd12, 32'd11);
    wait_done(lat);
    n_cmp++; if (lat !== 35 || result !== 32'd132 || remainder !== 32'd0) begin
      n_err++; $display("FAIL midrst_recover: got lat %0d %h/%h want 35 00000084/00000000", lat, result, remainder);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_div0();
    test_back_to_back();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
